// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum with fixed 3-bit encodings, retry counter width,
// and a helper that sizes the shared cycle counter from the timing parameters.
package pll_seq_pkg;

  localparam int RETRY_W = 4;
  localparam int STATE_W = 3;
  localparam int LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_t;

  // The counter only has to reach (largest interval - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the sequencer and the board/PLL side.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// master: sequencer side (locked, req_rst, clr_fault in; pll_rst, sys_rst_n,
//         ready, fault, retry_cnt, state_o out). slave: the mirror.
// Option macro PLL_SEQ_LOSS_COUNT_EN adds lock_loss_cnt (8 bits, sequencer out).
interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic               locked;
  logic               req_rst;
  logic               clr_fault;
  logic               pll_rst;
  logic               sys_rst_n;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [STATE_W-1:0] state_o;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [LOSS_W-1:0]  lock_loss_cnt;

  modport master (
    input  locked, req_rst, clr_fault,
    output pll_rst, sys_rst_n, ready, fault, retry_cnt, state_o, lock_loss_cnt
  );
  modport slave (
    output locked, req_rst, clr_fault,
    input  pll_rst, sys_rst_n, ready, fault, retry_cnt, state_o, lock_loss_cnt
  );
`else
  modport master (
    input  locked, req_rst, clr_fault,
    output pll_rst, sys_rst_n, ready, fault, retry_cnt, state_o
  );
  modport slave (
    output locked, req_rst, clr_fault,
    input  pll_rst, sys_rst_n, ready, fault, retry_cnt, state_o
  );
`endif

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous PLL lock flag into refclk.
// Latency: 2 clk cycles from input edge to q.
// Backpressure: none.
// Ports: clk, rst_n (async active-low, clears both flops), d (async in), q (sync out).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock with
// retries and a sticky fault, then releases the downstream reset.
// Latency: locked edge -> state change 3 refclk cycles (2 sync + 1 registered).
// Backpressure: none; req_rst/clr_fault are single-cycle pulses.
// Ports: refclk, rst_n (async active-low), bus (pll_reset_sequencer_if.master).
// Option macro PLL_SEQ_LOSS_COUNT_EN adds the saturating lock_loss_cnt output.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 10,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input logic                   refclk,
  input logic                   rst_n,
  pll_reset_sequencer_if.master bus
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  logic               locked_s;
  seq_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic               restart;
  // Low for the first refclk edge after reset release, so that edge starts
  // the pulse count instead of consuming one of its cycles.
  logic               started;
  logic               pll_rst_q, sys_rst_n_q, ready_q, fault_q;

  sync_2ff u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.locked),
    .q     (locked_s)
  );

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    restart   = 1'b0;

    // Software restart beats any lock-driven transition; FAULT is sticky.
    if (bus.req_rst && (state != FAULT)) begin
      restart   = 1'b1;
      state_nxt = RESET_PLL;
      retry_nxt = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (started && (cnt == PULSE_LAST)) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = STABILIZE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry == RETRY_LIMIT) begin
              state_nxt = FAULT;
            end else begin
              state_nxt = RESET_PLL;
              retry_nxt = retry + RETRY_W'(1);
            end
          end
        end
        STABILIZE: begin
          // A dropout goes back to waiting without costing a retry.
          if (!locked_s)                  state_nxt = WAIT_LOCK;
          else if (cnt == STABLE_LAST)    state_nxt = RUN;
        end
        RUN: begin
          if (!locked_s) state_nxt = RESET_PLL;
        end
        FAULT: begin
          if (bus.clr_fault) begin
            state_nxt = RESET_PLL;
            retry_nxt = '0;
          end
        end
        default: state_nxt = RESET_PLL;
      endcase
    end

    if (state_nxt == RUN) retry_nxt = '0;

    // Shared interval counter: zero on any state change (or restart),
    // counting only in the timed states.
    if (restart || (state_nxt != state)) begin
      cnt_nxt = '0;
    end else if (started && ((state == RESET_PLL) || (state == WAIT_LOCK) ||
                             (state == STABILIZE))) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else begin
      cnt_nxt = cnt;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge
  // as the state register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      retry       <= '0;
      started     <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry       <= retry_nxt;
      started     <= 1'b1;
      pll_rst_q   <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
      sys_rst_n_q <= (state_nxt == RUN);
      ready_q     <= (state_nxt == RUN);
      fault_q     <= (state_nxt == FAULT);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry;
  assign bus.state_o   = state;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  // Only a lock loss seen in RUN counts; a simultaneous req_rst takes the
  // transition, so it is excluded here.
  logic              loss_evt;
  logic [LOSS_W-1:0] loss_cnt;

  assign loss_evt = (state == RUN) && !locked_s && !bus.req_rst;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (loss_evt && (loss_cnt != {LOSS_W{1'b1}})) begin
      loss_cnt <= loss_cnt + LOSS_W'(1);
    end
  end

  assign bus.lock_loss_cnt = loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with
// RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
// Outputs are sampled 1 ns after each rising refclk edge.
module tb_pll_reset_sequencer;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pll_reset_sequencer_if bus();

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // Number of consecutive samples with pll_rst high, starting at the current one.
  task automatic pulse_len(output int n);
    n = 0;
    while (bus.pll_rst === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output int n);
    n = 0;
    while (bus.state_o !== s && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    bus.locked = 1'b0; bus.req_rst = 1'b0; bus.clr_fault = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b expected 1", bus.pll_rst); end
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n: got %b expected 0", bus.sys_rst_n); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", bus.fault); end
    checks++; if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", bus.retry_cnt); end
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++; if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_loss_cnt: got %0d expected 0", bus.lock_loss_cnt); end
`endif
    #2 rst_n = 1'b1;
    step();
    pulse_len(n);
    checks++; if (n != 4) begin errors++; $display("FAIL first_pulse_len: got %0d expected 4", n); end
    checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL after_pulse_state: got %0d expected 1", bus.state_o); end
  endtask

  task automatic test_normal_lock();
    int n;
    bit early;
    repeat (3) step();
    bus.locked = 1'b1;
    wait_state(3'd2, 10, n);
    checks++; if (bus.state_o !== 3'd2) begin errors++; $display("FAIL enter_stabilize: got %0d expected 2", bus.state_o); end
    n = 0; early = 1'b0;
    while (bus.state_o !== 3'd3 && n < 50) begin
      if (bus.ready !== 1'b0) early = 1'b1;
      step();
      n++;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL stabilize_len: got %0d expected 8", n); end
    checks++; if (early) begin errors++; $display("FAIL ready_early: got 1 expected 0"); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL run_ready: got %b expected 1", bus.ready); end
    checks++; if (bus.sys_rst_n !== 1'b1) begin errors++; $display("FAIL run_sys_rst_n: got %b expected 1", bus.sys_rst_n); end
    checks++; if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL run_retry: got %0d expected 0", bus.retry_cnt); end
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL run_pll_rst: got %b expected 0", bus.pll_rst); end
    bus.clr_fault = 1'b1;
    step();
    bus.clr_fault = 1'b0;
    step();
    checks++; if (bus.state_o !== 3'd3) begin errors++; $display("FAIL clr_fault_in_run: got %0d expected 3", bus.state_o); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL clr_fault_run_fault: got %b expected 0", bus.fault); end
  endtask

  task automatic test_glitch();
    int n;
    bit early;
    bus.req_rst = 1'b1;
    step();
    bus.req_rst = 1'b0;
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL req_rst_run_state: got %0d expected 0", bus.state_o); end
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL req_rst_sys_rst_n: got %b expected 0", bus.sys_rst_n); end
    wait_state(3'd2, 20, n);
    checks++; if (bus.state_o !== 3'd2) begin errors++; $display("FAIL glitch_stabilize: got %0d expected 2", bus.state_o); end
    step();
    step();
    bus.locked = 1'b0;
    step();
    bus.locked = 1'b1;
    wait_state(3'd1, 5, n);
    checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL glitch_back_to_wait: got %0d expected 1", bus.state_o); end
    wait_state(3'd2, 5, n);
    checks++; if (bus.state_o !== 3'd2) begin errors++; $display("FAIL glitch_restabilize: got %0d expected 2", bus.state_o); end
    n = 0; early = 1'b0;
    while (bus.state_o !== 3'd3 && n < 50) begin
      if (bus.ready !== 1'b0) early = 1'b1;
      step();
      n++;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL glitch_stable_len: got %0d expected 8", n); end
    checks++; if (early) begin errors++; $display("FAIL glitch_ready_early: got 1 expected 0"); end
  endtask

  task automatic test_loss_in_run();
    int n;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++; if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL loss_cnt_before: got %0d expected 0", bus.lock_loss_cnt); end
`endif
    bus.locked = 1'b0;
    n = 0;
    while (bus.sys_rst_n !== 1'b0 && n < 10) begin
      step();
      n++;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL loss_sys_rst_delay: got %0d expected 3", n); end
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL loss_state: got %0d expected 0", bus.state_o); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL loss_ready: got %b expected 0", bus.ready); end
    pulse_len(n);
    checks++; if (n != 4) begin errors++; $display("FAIL loss_pulse_len: got %0d expected 4", n); end
    step();
    bus.locked = 1'b1;
    wait_state(3'd3, 40, n);
    checks++; if (bus.state_o !== 3'd3) begin errors++; $display("FAIL loss_relock: got %0d expected 3", bus.state_o); end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++; if (bus.lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt_after: got %0d expected 1", bus.lock_loss_cnt); end
`endif
  endtask

  task automatic test_req_rst_priority();
    // locked_s reaches 0 two edges after locked falls; req_rst meets it on the third.
    bus.locked = 1'b0;
    step();
    step();
    bus.req_rst = 1'b1;
    step();
    bus.req_rst = 1'b0;
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL prio_state: got %0d expected 0", bus.state_o); end
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL prio_sys_rst_n: got %b expected 0", bus.sys_rst_n); end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++; if (bus.lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL prio_loss_cnt: got %0d expected 1", bus.lock_loss_cnt); end
`endif
  endtask

  task automatic test_never_locks();
    int n;
    for (int p = 0; p < 3; p++) begin
      if (p > 0) begin
        n = 0;
        while (bus.pll_rst !== 1'b1 && n < 40) begin
          step();
          n++;
        end
        checks++; if (n != 20) begin errors++; $display("FAIL timeout_len_%0d: got %0d expected 20", p, n); end
      end
      checks++; if (bus.retry_cnt !== 4'(p)) begin errors++; $display("FAIL retry_cnt_%0d: got %0d expected %0d", p, bus.retry_cnt, p); end
      pulse_len(n);
      checks++; if (n != 4) begin errors++; $display("FAIL retry_pulse_len_%0d: got %0d expected 4", p, n); end
    end
    n = 0;
    while (bus.fault !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++; if (n != 20) begin errors++; $display("FAIL fault_timeout_len: got %0d expected 20", n); end
    checks++; if (bus.state_o !== 3'd4) begin errors++; $display("FAIL fault_state: got %0d expected 4", bus.state_o); end
    checks++; if (bus.retry_cnt !== 4'd2) begin errors++; $display("FAIL fault_retry: got %0d expected 2", bus.retry_cnt); end
    repeat (5) step();
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL fault_pll_rst_held: got %b expected 1", bus.pll_rst); end
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL fault_sys_rst_n: got %b expected 0", bus.sys_rst_n); end
    bus.req_rst = 1'b1;
    step();
    bus.req_rst = 1'b0;
    step();
    checks++; if (bus.state_o !== 3'd4) begin errors++; $display("FAIL req_rst_in_fault: got %0d expected 4", bus.state_o); end
    checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL req_rst_fault_flag: got %b expected 1", bus.fault); end
  endtask

  task automatic test_clr_fault();
    int n;
    bus.clr_fault = 1'b1;
    step();
    bus.clr_fault = 1'b0;
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL clr_state: got %0d expected 0", bus.state_o); end
    checks++; if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL clr_retry: got %0d expected 0", bus.retry_cnt); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL clr_fault_flag: got %b expected 0", bus.fault); end
    pulse_len(n);
    checks++; if (n != 4) begin errors++; $display("FAIL clr_pulse_len: got %0d expected 4", n); end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++; if (bus.lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL clr_loss_cnt: got %0d expected 1", bus.lock_loss_cnt); end
`endif
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (bus.pll_rst !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++; if (bus.retry_cnt !== 4'd1) begin errors++; $display("FAIL pre_reset_retry: got %0d expected 1", bus.retry_cnt); end
    pulse_len(n);
    repeat (3) step();
    checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL pre_reset_state: got %0d expected 1", bus.state_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL async_pll_rst: got %b expected 1", bus.pll_rst); end
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL async_state: got %0d expected 0", bus.state_o); end
    checks++; if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL async_retry: got %0d expected 0", bus.retry_cnt); end
    checks++; if (bus.sys_rst_n !== 1'b0 || bus.ready !== 1'b0 || bus.fault !== 1'b0) begin
      errors++; $display("FAIL async_flags: got sys_rst_n=%b ready=%b fault=%b expected 0 0 0", bus.sys_rst_n, bus.ready, bus.fault);
    end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++; if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL async_loss_cnt: got %0d expected 0", bus.lock_loss_cnt); end
`endif
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    pulse_len(n);
    checks++; if (n != 4) begin errors++; $display("FAIL post_reset_pulse_len: got %0d expected 4", n); end
    checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL post_reset_state: got %0d expected 1", bus.state_o); end
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_glitch();
    test_loss_in_run();
    test_req_rst_priority();
    test_never_locks();
    test_clr_fault();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 ns");
    $fatal(1);
  end

endmodule
